// File: rtl/serializer_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serializer_ctrl_pkg : shared types and length-code helpers            |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package serializer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [3:0] MOD_FULL = 4'd0;
  localparam logic [3:0] MOD_ILL1 = 4'd1;
  localparam logic [3:0] MOD_ILL2 = 4'd2;

  // Codes 1 and 2 would shift too few bits for the busy handshake to be seen.
  function automatic logic is_legal_mod(input logic [3:0] mod);
    return (mod != MOD_ILL1) && (mod != MOD_ILL2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serializer_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serializer_ctrl_if : requester, config and serializer-side signals    |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface serializer_ctrl_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ*MOD_W-1:0]  req_mod_i;
  logic [N_REQ-1:0]        req_val_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ-1:0]        req_err_o;
  logic                    cfg_prio_i;
  logic [N_REQ-1:0]        cfg_mask_i;
  logic [DATA_W-1:0]       ser_data_o;
  logic [MOD_W-1:0]        ser_mod_o;
  logic                    ser_val_o;
  logic                    ser_busy_i;
  logic                    done_o;
  logic [ID_W-1:0]         done_id_o;

  modport slave (
    input  req_data_i, req_mod_i, req_val_i, cfg_prio_i, cfg_mask_i, ser_busy_i,
    output req_ready_o, req_err_o, ser_data_o, ser_mod_o, ser_val_o, done_o, done_id_o
  );

  modport master (
    output req_data_i, req_mod_i, req_val_i, cfg_prio_i, cfg_mask_i, ser_busy_i,
    input  req_ready_o, req_err_o, ser_data_o, ser_mod_o, ser_val_o, done_o, done_id_o
  );

endinterface
`default_nettype wire

// File: rtl/serializer_ctrl_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin / fixed-priority picker        |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  wire logic [N-1:0]  i_req,
  input  wire logic          i_prio_mode,
  input  wire logic [IW-1:0] i_ptr,
  output logic      [N-1:0]  o_grant,
  output logic      [IW-1:0] o_idx,
  output logic               o_valid
);

  logic [IW-1:0] w_start;
  logic [IW:0]   w_sum;
  logic          w_found;

  // Fixed priority is a round-robin scan that always starts at index 0.
  assign w_start = i_prio_mode ? '0 : i_ptr;

  always_comb begin
    w_sum   = '0;
    w_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, w_start} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      if (!w_found && i_req[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        o_idx   = w_sum[IW-1:0];
      end
    end
  end

  assign o_valid = w_found;
  assign o_grant = w_found ? (N'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/serializer_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serializer_ctrl : shares one serializer among N_REQ word requesters   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module serializer_ctrl
  import serializer_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input wire logic         clk_i,
  input wire logic         srst_i,
  serializer_ctrl_if.slave bus
);

  state_t             r_state, w_state_nxt;
  logic [ID_W-1:0]    r_ptr, r_id, w_idx;
  logic [N_REQ-1:0]   w_elig, w_grant, w_ready, r_err;
  logic               w_any, w_take, w_legal, w_done, r_val;
  logic [DATA_W-1:0]  w_sel_data, r_data;
  logic [MOD_W-1:0]   w_sel_mod, r_mod;

  assign w_elig = bus.req_val_i & ~bus.cfg_mask_i;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_req       (w_elig),
    .i_prio_mode (bus.cfg_prio_i),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_valid     (w_any)
  );

  assign w_sel_data = bus.req_data_i[w_idx*DATA_W +: DATA_W];
  assign w_sel_mod  = bus.req_mod_i[w_idx*MOD_W +: MOD_W];
  assign w_legal    = is_legal_mod(w_sel_mod);

  // A busy serializer in IDLE means it outlived us (reset race): hold off.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_ready     = '0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!srst_i && !bus.ser_busy_i && w_any) begin
          w_take  = 1'b1;
          w_ready = w_grant;
          if (w_legal) begin
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD:  w_state_nxt = SHIFT;
      SHIFT: begin
        if (!bus.ser_busy_i) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_data  <= '0;
      r_mod   <= '0;
      r_val   <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_val   <= 1'b0;
      r_err   <= '0;
      if (w_take) begin
        r_ptr <= (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;
        if (w_legal) begin
          r_data <= w_sel_data;
          r_mod  <= w_sel_mod;
          r_id   <= w_idx;
          r_val  <= 1'b1;
        end else begin
          r_err  <= w_grant;
        end
      end
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.req_err_o   = r_err;
  assign bus.ser_data_o  = r_data;
  assign bus.ser_mod_o   = r_mod;
  assign bus.ser_val_o   = r_val;
  assign bus.done_o      = w_done;
  assign bus.done_id_o   = r_id;

endmodule
`default_nettype wire

// File: tb/tb_serializer_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_serializer_ctrl : vectors, directed sequences, random vs timeline  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_serializer_ctrl;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 4;

  typedef struct { int cyc; int idx; } ev_t;
  typedef struct {
    logic [N-1:0] val;
    logic [N-1:0] mask;
    logic         prio;
    logic [N-1:0] exp_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  serializer_ctrl_if #(.N_REQ(N), .DATA_W(DW), .MOD_W(MW)) bus ();
  serializer_ctrl #(.N_REQ(N), .DATA_W(DW), .MOD_W(MW)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  logic [N-1:0]  val, mask, rdy_seen;
  logic          prio;
  logic [DW-1:0] dat [N];
  logic [MW-1:0] md  [N];
  bit            mdl_en, auto_drop;
  int            cyc = 0;
  int            n_checks = 0, n_fail = 0;

  always_comb begin
    bus.req_val_i  = val;
    bus.cfg_mask_i = mask;
    bus.cfg_prio_i = prio;
    bus.req_data_i = '0;
    bus.req_mod_i  = '0;
    for (int k = 0; k < N; k++) begin
      bus.req_data_i[k*DW +: DW] = dat[k];
      bus.req_mod_i[k*MW +: MW]  = md[k];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mod_len(input logic [MW-1:0] m);
    return (m == 0) ? 16 : int'(m);
  endfunction

  function automatic bit mod_ok(input logic [MW-1:0] m);
    return !(m == 1 || m == 2);
  endfunction

  // Winner = eligible requester closest to the start point going upward.
  function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] m,
                              input logic p, input int ptr);
    int best, bestd, d;
    best = -1; bestd = N;
    for (int k = 0; k < N; k++) begin
      if (v[k] && !m[k]) begin
        d = p ? k : (k - ptr + N) % N;
        if (d < bestd) begin bestd = d; best = k; end
      end
    end
    return best;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in serializer: first bit with the launch strobe, busy for the rest.
  logic [DW-1:0] ser_sh = '0;
  int            ser_cnt = 0;
  always @(posedge clk) begin
    if (srst) begin
      ser_cnt <= 0;
      ser_sh  <= '0;
    end else if (bus.ser_val_o) begin
      ser_sh  <= bus.ser_data_o << 1;
      ser_cnt <= mod_len(bus.ser_mod_o) - 1;
    end else if (ser_cnt != 0) begin
      ser_sh  <= ser_sh << 1;
      ser_cnt <= ser_cnt - 1;
    end
  end
  assign bus.ser_busy_i = (ser_cnt != 0);

  // Transaction timeline: grant at c -> launch c+1, done c+L+1, free c+L+2.
  int            m_ptr = 0, m_free_at = 0, m_launch_at = -1, m_done_at = -1;
  int            m_err_at = -1, m_id = 0, win;
  logic [DW-1:0] m_data = '0;
  logic [MW-1:0] m_mod = '0;
  logic [N-1:0]  m_err_mask = '0, exp_rdy;
  ev_t           grant_q[$], done_q[$], err_q[$], ev;
  int            launch_q[$];
  bit            bits_q[$];

  initial begin
    forever begin
      @(negedge clk);
      win = -1;
      if (!srst && cyc >= m_free_at) win = pick(val, mask, prio, m_ptr);
      exp_rdy = (win >= 0) ? N'(1 << win) : '0;
      if (mdl_en) begin
        chk("ready", 32'(bus.req_ready_o), 32'(exp_rdy));
        chk("ser_val", 32'(bus.ser_val_o), 32'(cyc == m_launch_at));
        if (cyc == m_launch_at) begin
          chk("ser_data", 32'(bus.ser_data_o), 32'(m_data));
          chk("ser_mod", 32'(bus.ser_mod_o), 32'(m_mod));
        end
        chk("done", 32'(bus.done_o), 32'(cyc == m_done_at));
        if (cyc == m_done_at) chk("done_id", 32'(bus.done_id_o), 32'(m_id));
        chk("err", 32'(bus.req_err_o), 32'((cyc == m_err_at) ? m_err_mask : {N{1'b0}}));
      end
      if (srst) begin
        m_ptr = 0; m_free_at = cyc + 1;
        m_launch_at = -1; m_done_at = -1; m_err_at = -1;
      end else if (mdl_en && win >= 0) begin
        m_ptr = (win + 1) % N;
        if (mod_ok(md[win])) begin
          m_launch_at = cyc + 1;
          m_done_at   = cyc + mod_len(md[win]) + 1;
          m_free_at   = cyc + mod_len(md[win]) + 2;
          m_data = dat[win]; m_mod = md[win]; m_id = win;
        end else begin
          m_err_at = cyc + 1; m_err_mask = N'(1 << win); m_free_at = cyc + 1;
        end
      end
      rdy_seen = bus.req_ready_o;
      if (bus.req_ready_o != '0) begin ev.cyc = cyc; ev.idx = oh2i(bus.req_ready_o); grant_q.push_back(ev); end
      if (bus.req_err_o != '0)   begin ev.cyc = cyc; ev.idx = oh2i(bus.req_err_o);   err_q.push_back(ev);   end
      if (bus.done_o)            begin ev.cyc = cyc; ev.idx = int'(bus.done_id_o);   done_q.push_back(ev);  end
      if (bus.ser_val_o) begin
        launch_q.push_back(cyc);
        bits_q.push_back(bus.ser_data_o[DW-1]);
      end else if (bus.ser_busy_i) begin
        bits_q.push_back(ser_sh[DW-1]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      if (auto_drop) val = val & ~rdy_seen;
    end
  endtask

  task automatic drain();
    val = '0;
    repeat (25) step();
  endtask

  task automatic clear_q();
    grant_q.delete(); done_q.delete(); err_q.delete(); launch_q.delete(); bits_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ser_val"},  32'(bus.ser_val_o), 32'(0));
    chk({tag, "_ser_data"}, 32'(bus.ser_data_o), 32'(0));
    chk({tag, "_ser_mod"},  32'(bus.ser_mod_o), 32'(0));
    chk({tag, "_ready"},    32'(bus.req_ready_o), 32'(0));
    chk({tag, "_err"},      32'(bus.req_err_o), 32'(0));
    chk({tag, "_done"},     32'(bus.done_o), 32'(0));
    chk({tag, "_done_id"},  32'(bus.done_id_o), 32'(0));
  endtask

  function automatic logic [MW-1:0] rand_mod();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return MW'($urandom_range(1, 2));
    return MW'($urandom_range(3, 15));
  endfunction

  vec_t vt[9];
  logic [DW-1:0] word;
  int cnt;

  initial begin
    val = '0; mask = '0; prio = 1'b0; mdl_en = 1'b0; auto_drop = 1'b1;
    for (int k = 0; k < N; k++) begin dat[k] = '0; md[k] = 4'd5; end
    srst = 1'b1;
    repeat (3) step();
    srst = 1'b0;
    @(negedge clk);
    chk_reset("por");

    // Combinational arbitration at pointer 0; requests withdrawn before the edge.
    vt[0] = '{4'b1010, 4'b0000, 1'b0, 4'b0010};
    vt[1] = '{4'b1010, 4'b0000, 1'b1, 4'b0010};
    vt[2] = '{4'b1111, 4'b0001, 1'b0, 4'b0010};
    vt[3] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
    vt[4] = '{4'b1000, 4'b1000, 1'b1, 4'b0000};
    vt[5] = '{4'b1100, 4'b0000, 1'b1, 4'b0100};
    vt[6] = '{4'b1001, 4'b0000, 1'b0, 4'b0001};
    vt[7] = '{4'b1111, 4'b1110, 1'b1, 4'b0001};
    vt[8] = '{4'b0110, 4'b0010, 1'b0, 4'b0100};
    for (int i = 0; i < 9; i++) begin
      step();
      val = vt[i].val; mask = vt[i].mask; prio = vt[i].prio;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready_o), 32'(vt[i].exp_rdy));
      #1 val = '0;
    end
    mask = '0; prio = 1'b0;
    step(); step();
    mdl_en = 1'b1;

    // Single 16-bit word from requester 0.
    clear_q();
    dat[0] = 16'hA5C3; md[0] = 4'd0; val = 4'b0001;
    run(24);
    chk("s1_grants", 32'(grant_q.size()), 32'(1));
    chk("s1_launches", 32'(launch_q.size()), 32'(1));
    chk("s1_dones", 32'(done_q.size()), 32'(1));
    chk("s1_nbits", 32'(bits_q.size()), 32'(16));
    if (grant_q.size() > 0 && launch_q.size() > 0) begin
      chk("s1_grant_id", 32'(grant_q[0].idx), 32'(0));
      chk("s1_launch_lat", 32'(launch_q[0] - grant_q[0].cyc), 32'(1));
    end
    if (done_q.size() > 0 && launch_q.size() > 0) begin
      chk("s1_done_lat", 32'(done_q[0].cyc - launch_q[0]), 32'(16));
      chk("s1_done_id", 32'(done_q[0].idx), 32'(0));
    end
    word = '0;
    for (int i = 0; i < 16 && i < bits_q.size(); i++) word = {word[DW-2:0], 1'(bits_q[i])};
    chk("s1_bits", 32'(word), 32'(16'hA5C3));

    // Round-robin across four always-valid requesters after a fresh reset.
    srst = 1'b1; step(); srst = 1'b0;
    clear_q();
    for (int k = 0; k < N; k++) begin md[k] = 4'd5; dat[k] = 16'(16'h1111 * (k + 1)); end
    auto_drop = 1'b0; val = 4'b1111;
    run(30);
    val = '0; auto_drop = 1'b1;
    run(12);
    chk("s2_ngrants", 32'(grant_q.size() >= 5), 32'(1));
    for (int i = 0; i < 5 && i < grant_q.size(); i++)
      chk($sformatf("s2_order%0d", i), 32'(grant_q[i].idx), 32'(i % 4));
    for (int i = 1; i < 5 && i < launch_q.size(); i++)
      chk($sformatf("s2_gap%0d", i), 32'(launch_q[i] - launch_q[i-1]), 32'(7));

    // Fixed priority: 1 starves 3 until it withdraws.
    clear_q();
    prio = 1'b1; md[1] = 4'd3; md[3] = 4'd3; auto_drop = 1'b0; val = 4'b1010;
    run(30);
    cnt = 0;
    foreach (grant_q[i]) if (grant_q[i].idx != 1) cnt++;
    chk("s3_only1", 32'(cnt), 32'(0));
    chk("s3_many", 32'(grant_q.size() >= 4), 32'(1));
    grant_q.delete();
    auto_drop = 1'b1; val = 4'b1000;
    run(12);
    chk("s3_n3", 32'(grant_q.size()), 32'(1));
    if (grant_q.size() > 0) chk("s3_id3", 32'(grant_q[0].idx), 32'(3));
    prio = 1'b0;
    drain();

    // Illegal length code is consumed in one cycle and flagged.
    clear_q();
    md[2] = 4'd1; md[3] = 4'd4; dat[2] = 16'hDEAD; dat[3] = 16'hBEEF; val = 4'b1100;
    run(12);
    chk("s4_ngrants", 32'(grant_q.size()), 32'(2));
    chk("s4_nerr", 32'(err_q.size()), 32'(1));
    chk("s4_nlaunch", 32'(launch_q.size()), 32'(1));
    if (grant_q.size() == 2 && err_q.size() == 1 && launch_q.size() == 1) begin
      chk("s4_first", 32'(grant_q[0].idx), 32'(2));
      chk("s4_second", 32'(grant_q[1].idx), 32'(3));
      chk("s4_back2back", 32'(grant_q[1].cyc - grant_q[0].cyc), 32'(1));
      chk("s4_err_id", 32'(err_q[0].idx), 32'(2));
      chk("s4_err_lat", 32'(err_q[0].cyc - grant_q[0].cyc), 32'(1));
      chk("s4_launch", 32'(launch_q[0] - grant_q[1].cyc), 32'(1));
    end
    drain();

    // Mask requester 0, then unmask mid-transfer.
    clear_q();
    mask = 4'b0001; md[0] = 4'd6; md[1] = 4'd6; val = 4'b0011;
    run(4);
    mask = '0;
    run(12);
    chk("s5_ngrants", 32'(grant_q.size()), 32'(2));
    if (grant_q.size() == 2) begin
      chk("s5_first", 32'(grant_q[0].idx), 32'(1));
      chk("s5_second", 32'(grant_q[1].idx), 32'(0));
      chk("s5_gap", 32'(grant_q[1].cyc - grant_q[0].cyc), 32'(8));
    end
    drain();

    // Reset five cycles into a 16-bit word.
    clear_q();
    md[0] = 4'd0; dat[0] = 16'h3C5A; val = 4'b0001;
    run(6);
    srst = 1'b1; step(); srst = 1'b0;
    done_q.delete();
    @(negedge clk);
    chk_reset("mid");
    run(20);
    chk("s6_no_done", 32'(done_q.size()), 32'(0));
    clear_q();
    md[0] = 4'd4; md[1] = 4'd4; val = 4'b0011;
    run(14);
    chk("s6_ngrants", 32'(grant_q.size() >= 1), 32'(1));
    if (grant_q.size() > 0 && launch_q.size() > 0 && done_q.size() > 0) begin
      chk("s6_ptr0", 32'(grant_q[0].idx), 32'(0));
      chk("s6_launch", 32'(launch_q[0] - grant_q[0].cyc), 32'(1));
      chk("s6_done", 32'(done_q[0].cyc - launch_q[0]), 32'(4));
    end
    drain();

    // Random traffic, config churn and occasional resets against the timeline.
    for (int i = 0; i < 3000; i++) begin
      step();
      val = val & ~rdy_seen;
      for (int k = 0; k < N; k++) begin
        if (val[k] && $urandom_range(0, 31) == 0) begin
          val[k] = 1'b0;
        end else if (!val[k] && $urandom_range(0, 3) == 0) begin
          val[k] = 1'b1; dat[k] = 16'($urandom); md[k] = rand_mod();
        end
      end
      if ($urandom_range(0, 63) == 0) mask = N'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) prio = 1'($urandom_range(0, 1));
      srst = ($urandom_range(0, 499) == 0);
    end
    srst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serializer_ctrl.md
# serializer_ctrl

Round-robin / fixed-priority controller that shares one 16-bit parallel-to-serial converter between N_REQ requesters. It arbitrates among pending words and launches exactly one word per converter transfer. It tracks the converter's busy flag and reports completion per transfer. It sits between the packet-assembly logic and the serializer, driving the serializer's data/mod/valid inputs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, word width; fixed to the serializer width
- MOD_W, 4, length-code width
- clk_i  in  1  clock
- srst_i  in  1  synchronous active-high reset
- req_data_i  in  N_REQ*DATA_W  per-requester word; MSB is sent first
- req_mod_i  in  N_REQ*MOD_W  per-requester length code: 0 = 16 bits, 3..15 = that many bits, 1/2 = illegal
- req_val_i  in  N_REQ  request valid; held with data until ready
- req_ready_o  out  N_REQ  one-hot, combinational accept strobe
- req_err_o  out  N_REQ  registered one-cycle pulse: word with illegal mod was consumed and discarded
- cfg_prio_i  in  1  0 = round-robin, 1 = fixed priority (index 0 highest)
- cfg_mask_i  in  N_REQ  1 = requester disabled
- ser_data_o  out  DATA_W  word to the serializer, registered
- ser_mod_o  out  MOD_W  length code to the serializer, registered
- ser_val_o  out  1  one-cycle launch strobe, registered
- ser_busy_i  in  1  serializer busy flag
- done_o  out  1  one-cycle pulse when a launched word has finished shifting
- done_id_o  out  $clog2(N_REQ)  requester index of the finished word, valid with done_o

## Operation
- FSM states:
  - IDLE: arbitrate.
  - LOAD: ser_val_o high.
  - SHIFT: wait for busy to drop.
- Eligible requester: req_val_i[k] & ~cfg_mask_i[k].
- IDLE, ser_busy_i=0, any eligible requester:
  - Arbiter picks winner k.
  - req_ready_o[k]=1 this cycle.
  - Legal mod: capture data, mod and id into output regs; go to LOAD.
  - Illegal mod (1 or 2): word dropped, req_err_o[k] pulses next cycle, stay IDLE, pointer advances.
- IDLE with ser_busy_i=1: no grant. This covers an external reset race.
- LOAD: ser_val_o=1 for exactly one cycle; go to SHIFT.
- SHIFT:
  - ser_busy_i=1: stay.
  - ser_busy_i=0: done_o=1 and done_id_o=captured id (combinational); go to IDLE.
- Round-robin: after every consumed word (legal or illegal), pointer = winner+1 mod N_REQ. Search starts at the pointer.
- Fixed priority: lowest eligible index wins; the pointer still updates but is ignored.
- Config inputs are sampled only in IDLE. Changes mid-transfer affect the next arbitration only.
- Requester dropping req_val_i without ready: allowed, no side effects.

## Timing
- Reset values:
  - state IDLE, RR pointer 0.
  - ser_val_o=0, ser_data_o=0, ser_mod_o=0.
  - req_ready_o=0, req_err_o=0, done_o=0, done_id_o=0.
- Grant at cycle t gives ser_val_o at t+1. Serializer busy is high from t+2.
- Word of L bits (L=16 for mod 0): bits appear t+1..t+L, ser_busy_i falls at t+L+1, done_o at t+L+1.
- Next grant is no earlier than t+L+2, so the next launch is at t+L+3.
- Minimum L is 3, which guarantees busy is high at t+2. SHIFT never sees a stale low.
- Illegal-mod consumption takes one cycle; the next arbitration is at t+1.
- srst_i mid-transfer: everything returns to the reset values next cycle. No done_o for the aborted word. The serializer shares srst_i.
- At most one bit of req_ready_o is set per cycle.

## Structure
- serializer_ctrl_pkg holds:
  - state enum (IDLE, LOAD, SHIFT)
  - MOD_FULL=0, MOD_ILL1=1, MOD_ILL2=2
  - is_legal_mod() function
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, prio_mode, ptr.
  - Outputs: one-hot grant, encoded index.
  - Purely combinational; the pointer register lives in serializer_ctrl.

## Test plan
- Single requester 0:
  - Stimulus: data 0xA5C3, mod 0.
  - Required: ser_val_o one cycle after ready; 16 serial bits 1010010111000011; done_o with id 0 at launch+16.
- Round-robin:
  - Stimulus: requesters 0..3 all valid, mod 5, cfg_prio_i=0.
  - Required: grants in order 0,1,2,3,0; each launch 7 cycles after the previous.
- Fixed priority:
  - Stimulus: requesters 1 and 3 held valid, cfg_prio_i=1.
  - Required: requester 1 is granted repeatedly; 3 is never granted until 1 drops valid.
- Illegal mod:
  - Stimulus: requester 2 with mod 1, requester 3 with mod 4.
  - Required: ready[2] then req_err_o[2] pulse, no ser_val_o for it; requester 3 granted the next cycle.
- Mask:
  - Stimulus: cfg_mask_i=0b0001 with requesters 0 and 1 valid.
  - Required: only 1 is granted. Clearing the mask during SHIFT lets 0 win the next IDLE.
- Reset mid-transfer:
  - Stimulus: srst_i pulsed 5 cycles into a 16-bit word.
  - Required: all outputs at reset values, no done_o, pointer 0; a fresh request launches normally.
